// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and host-side frame builders.
package loader_pkg;

    localparam int LOADER_WORD_W = 16;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } loader_state_t;

    // Running frame checksum: byte-wise XOR.
    function automatic logic [7:0] xor_byte(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Parses a framed byte stream (sync, 16-bit length, big-endian words, XOR
// checksum) and emits one instruction-store write per assembled word,
// holding the CPU halted while a load is in progress.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 32,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [LOADER_WORD_W-1:0] wr_addr,
    output logic [LOADER_WORD_W-1:0] wr_data,
    output logic                     cpu_halt,
    output logic                     done,
    output logic                     error,
    output logic [LOADER_WORD_W-1:0] words_loaded
);

    localparam logic [LOADER_WORD_W:0] MEM_LIMIT = (LOADER_WORD_W+1)'(MEM_SIZE);

    loader_state_t            state_q;
    logic                     in_ready_q;
    logic                     wr_en_q;
    logic [LOADER_WORD_W-1:0] wr_addr_q;
    logic [LOADER_WORD_W-1:0] wr_data_q;
    logic                     cpu_halt_q;
    logic                     done_q;
    logic                     error_q;
    logic [LOADER_WORD_W-1:0] words_q;
    logic [LOADER_WORD_W-1:0] len_q;
    logic [7:0]               len_hi_q;
    logic [7:0]               data_hi_q;
    logic [7:0]               chk_q;

    logic                     accept_d;
    logic [7:0]               chk_d;
    logic [LOADER_WORD_W-1:0] len_d;
    logic [LOADER_WORD_W-1:0] words_d;

    assign accept_d = in_valid && in_ready_q;
    assign chk_d    = xor_byte(chk_q, in_data);
    assign len_d    = {len_hi_q, in_data};
    assign words_d  = words_q + LOADER_WORD_W'(1);

    // Frame parser FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_halt_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
            len_q      <= '0;
            len_hi_q   <= '0;
            data_hi_q  <= '0;
            chk_q      <= '0;
        end else begin
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            if (accept_d) begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (in_data == SYNC_BYTE) begin
                            state_q    <= S_LEN_HI;
                            cpu_halt_q <= 1'b1;
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                            words_q    <= '0;
                            chk_q      <= '0;
                        end
                    end
                    S_LEN_HI: begin
                        len_hi_q <= in_data;
                        chk_q    <= chk_d;
                        state_q  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_q <= len_d;
                        chk_q <= chk_d;
                        if ({1'b0, len_d} > MEM_LIMIT) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else if (len_d == '0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: begin
                        data_hi_q <= in_data;
                        chk_q     <= chk_d;
                        state_q   <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= words_q;
                        wr_data_q <= {data_hi_q, in_data};
                        words_q   <= words_d;
                        chk_q     <= chk_d;
                        state_q   <= (words_d == len_q) ? S_CHECK : S_DATA_HI;
                    end
                    S_CHECK: begin
                        if (in_data == chk_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_halt_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cpu_halt     = cpu_halt_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule
